trigger_seq: RTL and testbench

Parametrised multi-stage sequential trigger for the logic-analyser capture path. It sits between the sampler (strobe plus samples) and the capture controller (run flag). It generalises the fixed 4-stage/32-channel trigger to configurable stage and channel counts. It adds per-stage delay counters, rising-edge match mode and saturating level sequencing.

---
 rtl/trigger_seq.sv | 167 ++++++++++++++++
 tb/tb_trigger_seq.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/trigger_seq.sv
// trigger_seq: parametrised multi-stage sequential trigger for the capture path.
// Each stage matches masked sample values (optionally on a rising edge), may
// wait a strobe-counted delay, and either advances the sequencer level or
// starts the capture by raising the sticky run flag.
module trigger_seq #(
    parameter int STAGES = 4,
    parameter int WIDTH  = 32,
    parameter int LVL_W  = $clog2(STAGES)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [31:0]      cmd_i,
    input  logic [LVL_W-1:0] stg_i,
    input  logic             set_mask_i,
    input  logic             set_val_i,
    input  logic             set_cfg_i,
    input  logic             exec_i,
    input  logic             arm_i,
    input  logic             stb_i,
    input  logic [WIDTH-1:0] smpls_i,
    output logic             run_o,
    output logic             armed_o,
    output logic [LVL_W-1:0] lvl_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DELAY,
        S_DONE
    } stage_t;

    localparam logic [LVL_W-1:0] LVL_MAX = LVL_W'(STAGES - 1);

    // per-stage configuration
    logic [WIDTH-1:0] mask_q  [STAGES];
    logic [WIDTH-1:0] val_q   [STAGES];
    logic [15:0]      dly_q   [STAGES];
    logic [LVL_W-1:0] lev_q   [STAGES];
    logic             edge_q  [STAGES];
    logic             start_q [STAGES];

    // per-stage sequencing state
    stage_t           st_q    [STAGES];
    logic [15:0]      cnt_q   [STAGES];

    logic [WIDTH-1:0] prev_q;
    logic             armed_q;
    logic             run_q;
    logic [LVL_W-1:0] lvl_q;

    logic [STAGES-1:0] hit;
    logic [STAGES-1:0] elig;
    logic [STAGES-1:0] fire;
    logic [STAGES-1:0] start_fire;

    // only part of the command word is meaningful for a given WIDTH/LVL_W
    logic unused_cmd;
    assign unused_cmd = ^cmd_i;

    // match, eligibility and fire decode for every stage on the current sample
    always_comb begin
        hit        = '0;
        elig       = '0;
        fire       = '0;
        start_fire = '0;
        for (int unsigned i = 0; i < STAGES; i++) begin
            hit[i] = (((smpls_i ^ val_q[i]) & mask_q[i]) == '0) &&
                     (!edge_q[i] || (((smpls_i ^ prev_q) & smpls_i & mask_q[i]) != '0));
            elig[i] = armed_q && (st_q[i] == S_WAIT) && (lev_q[i] == lvl_q);
            fire[i] = stb_i && !arm_i &&
                      ((elig[i] && hit[i] && (dly_q[i] == 16'd0)) ||
                       ((st_q[i] == S_DELAY) && (cnt_q[i] == 16'd1)));
            start_fire[i] = fire[i] && start_q[i];
        end
    end

    // configuration writes, stage FSMs, level sequencer and run/armed flags
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            prev_q  <= '0;
            armed_q <= 1'b0;
            run_q   <= 1'b0;
            lvl_q   <= '0;
            for (int unsigned i = 0; i < STAGES; i++) begin
                mask_q[i]  <= '0;
                val_q[i]   <= '0;
                dly_q[i]   <= '0;
                lev_q[i]   <= '0;
                edge_q[i]  <= 1'b0;
                start_q[i] <= 1'b0;
                st_q[i]    <= S_IDLE;
                cnt_q[i]   <= '0;
            end
        end else begin
            if (stb_i) begin
                prev_q <= smpls_i;
            end

            // stage index compared per slot so out-of-range targets match nothing
            for (int unsigned i = 0; i < STAGES; i++) begin
                if (exec_i && (stg_i == LVL_W'(i))) begin
                    if (set_mask_i) mask_q[i] <= cmd_i[WIDTH-1:0];
                    if (set_val_i)  val_q[i]  <= cmd_i[WIDTH-1:0];
                    if (set_cfg_i) begin
                        dly_q[i]   <= cmd_i[15:0];
                        lev_q[i]   <= cmd_i[16 +: LVL_W];
                        edge_q[i]  <= cmd_i[26];
                        start_q[i] <= cmd_i[27];
                    end
                end
            end

            if (arm_i) begin
                armed_q <= 1'b1;
                run_q   <= 1'b0;
                lvl_q   <= '0;
                for (int unsigned i = 0; i < STAGES; i++) begin
                    st_q[i]  <= S_WAIT;
                    cnt_q[i] <= '0;
                end
            end else if (stb_i) begin
                if (|start_fire) begin
                    run_q   <= 1'b1;
                    armed_q <= 1'b0;
                    for (int unsigned i = 0; i < STAGES; i++) begin
                        st_q[i]  <= S_IDLE;
                        cnt_q[i] <= '0;
                    end
                end else begin
                    if ((|fire) && (lvl_q != LVL_MAX)) begin
                        lvl_q <= lvl_q + 1'b1;
                    end
                    for (int unsigned i = 0; i < STAGES; i++) begin
                        case (st_q[i])
                            S_WAIT: begin
                                if (elig[i] && hit[i]) begin
                                    if (dly_q[i] == 16'd0) begin
                                        st_q[i] <= S_DONE;
                                    end else begin
                                        cnt_q[i] <= dly_q[i];
                                        st_q[i]  <= S_DELAY;
                                    end
                                end
                            end
                            S_DELAY: begin
                                if (cnt_q[i] == 16'd1) begin
                                    cnt_q[i] <= '0;
                                    st_q[i]  <= S_DONE;
                                end else begin
                                    cnt_q[i] <= cnt_q[i] - 16'd1;
                                end
                            end
                            default: begin
                            end
                        endcase
                    end
                end
            end
        end
    end

    assign run_o   = run_q;
    assign armed_o = armed_q;
    assign lvl_o   = lvl_q;

endmodule

// File: tb/tb_trigger_seq.sv
// tb_trigger_seq: scoreboard bench for trigger_seq with STAGES=4, WIDTH=8.
module tb_trigger_seq;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [31:0] cmd_i = '0;
    logic [1:0]  stg_i = '0;
    logic        set_mask_i = 1'b0;
    logic        set_val_i = 1'b0;
    logic        set_cfg_i = 1'b0;
    logic        exec_i = 1'b0;
    logic        arm_i = 1'b0;
    logic        stb_i = 1'b0;
    logic [7:0]  smpls_i = '0;
    logic        run_o;
    logic        armed_o;
    logic [1:0]  lvl_o;

    typedef struct {
        string      tag;
        logic       run;
        logic       armed;
        logic [1:0] lvl;
    } exp_t;

    exp_t exp_q [$];
    int   checks = 0;
    int   errors = 0;

    trigger_seq #(.STAGES(4), .WIDTH(8)) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .cmd_i      (cmd_i),
        .stg_i      (stg_i),
        .set_mask_i (set_mask_i),
        .set_val_i  (set_val_i),
        .set_cfg_i  (set_cfg_i),
        .exec_i     (exec_i),
        .arm_i      (arm_i),
        .stb_i      (stb_i),
        .smpls_i    (smpls_i),
        .run_o      (run_o),
        .armed_o    (armed_o),
        .lvl_o      (lvl_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] cfgw(input logic [15:0] d, input logic [1:0] l,
                                         input logic e, input logic s);
        logic [31:0] w;
        w        = '0;
        w[15:0]  = d;
        w[17:16] = l;
        w[26]    = e;
        w[27]    = s;
        return w;
    endfunction

    task automatic wr(input logic [1:0] stg, input logic m, input logic v, input logic c,
                      input logic [31:0] cmd);
        @(negedge clk_i);
        stg_i = stg; set_mask_i = m; set_val_i = v; set_cfg_i = c; exec_i = 1'b1; cmd_i = cmd;
        @(posedge clk_i);
        #1;
        set_mask_i = 1'b0; set_val_i = 1'b0; set_cfg_i = 1'b0; exec_i = 1'b0; cmd_i = '0;
    endtask

    task automatic setup(input logic [1:0] stg, input logic [7:0] mask, input logic [7:0] val,
                         input logic [31:0] cfg);
        wr(stg, 1'b1, 1'b0, 1'b0, {24'h0, mask});
        wr(stg, 1'b0, 1'b1, 1'b0, {24'h0, val});
        wr(stg, 1'b0, 1'b0, 1'b1, cfg);
    endtask

    // zero mask in edge mode can never match, taking the stage out of play
    task automatic park(input logic [1:0] stg);
        setup(stg, 8'h00, 8'h00, cfgw(16'd0, 2'd0, 1'b1, 1'b0));
    endtask

    task automatic step(input string tag, input logic rst, input logic arm, input logic stb,
                        input logic [7:0] s, input logic er, input logic ea, input logic [1:0] el);
        exp_t e;
        exp_q.push_back('{tag, er, ea, el});
        @(negedge clk_i);
        rst_i = rst; arm_i = arm; stb_i = stb; smpls_i = s;
        @(posedge clk_i);
        #1;
        rst_i = 1'b0; arm_i = 1'b0; stb_i = 1'b0;
        e = exp_q.pop_front();
        check({e.tag, ".run"},   {31'h0, run_o},   {31'h0, e.run});
        check({e.tag, ".armed"}, {31'h0, armed_o}, {31'h0, e.armed});
        check({e.tag, ".lvl"},   {30'h0, lvl_o},   {30'h0, e.lvl});
    endtask

    initial begin
        // reset state
        rst_i = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;
        check("rst.run",   {31'h0, run_o},   32'h0);
        check("rst.armed", {31'h0, armed_o}, 32'h0);
        check("rst.lvl",   {30'h0, lvl_o},   32'h0);
        @(negedge clk_i);
        rst_i = 1'b0;

        // 1: single-stage level match
        park(2'd1); park(2'd2); park(2'd3);
        setup(2'd0, 8'h0F, 8'h05, cfgw(16'd0, 2'd0, 1'b0, 1'b1));
        step("t1.arm",  0, 1, 0, 8'h00, 0, 1, 2'd0);
        step("t1.s14",  0, 0, 1, 8'h14, 0, 1, 2'd0);
        step("t1.s35",  0, 0, 1, 8'h35, 1, 0, 2'd0);
        step("t1.hold", 0, 0, 0, 8'h00, 1, 0, 2'd0);

        // 2: two-level sequence
        setup(2'd0, 8'hFF, 8'h01, cfgw(16'd0, 2'd0, 1'b0, 1'b0));
        setup(2'd1, 8'hFF, 8'h02, cfgw(16'd0, 2'd1, 1'b0, 1'b1));
        step("t2.arm", 0, 1, 0, 8'h00, 0, 1, 2'd0);
        step("t2.s02", 0, 0, 1, 8'h02, 0, 1, 2'd0);
        step("t2.s01", 0, 0, 1, 8'h01, 0, 1, 2'd1);
        step("t2.idl", 0, 0, 0, 8'h02, 0, 1, 2'd1);
        step("t2.s02b",0, 0, 1, 8'h02, 1, 0, 2'd1);

        // 3: delay of three strobes
        park(2'd1);
        setup(2'd0, 8'hFF, 8'hAA, cfgw(16'd3, 2'd0, 1'b0, 1'b1));
        step("t3.arm",  0, 1, 0, 8'h00, 0, 1, 2'd0);
        step("t3.hit",  0, 0, 1, 8'hAA, 0, 1, 2'd0);
        step("t3.i0",   0, 0, 0, 8'h00, 0, 1, 2'd0);
        step("t3.d1",   0, 0, 1, 8'h00, 0, 1, 2'd0);
        step("t3.i1",   0, 0, 0, 8'h00, 0, 1, 2'd0);
        step("t3.d2",   0, 0, 1, 8'h00, 0, 1, 2'd0);
        step("t3.i2",   0, 0, 0, 8'h00, 0, 1, 2'd0);
        step("t3.d3",   0, 0, 1, 8'h00, 1, 0, 2'd0);

        // 4: rising-edge mode, prev=0x00 then prev=0x01
        setup(2'd0, 8'h01, 8'h01, cfgw(16'd0, 2'd0, 1'b1, 1'b1));
        step("t4.arm",  0, 1, 0, 8'h00, 0, 1, 2'd0);
        step("t4.r01",  0, 0, 1, 8'h01, 1, 0, 2'd0);
        step("t4.arm2", 0, 1, 0, 8'h00, 0, 1, 2'd0);
        step("t4.h01a", 0, 0, 1, 8'h01, 0, 1, 2'd0);
        step("t4.h01b", 0, 0, 1, 8'h01, 0, 1, 2'd0);
        step("t4.f00",  0, 0, 1, 8'h00, 0, 1, 2'd0);
        step("t4.r01b", 0, 0, 1, 8'h01, 1, 0, 2'd0);

        // 5a: two stages firing together advance lvl by one
        setup(2'd0, 8'h0F, 8'h03, cfgw(16'd0, 2'd0, 1'b0, 1'b0));
        setup(2'd1, 8'hF0, 8'h00, cfgw(16'd0, 2'd0, 1'b0, 1'b0));
        step("t5.arm",  0, 1, 0, 8'h00, 0, 1, 2'd0);
        step("t5.dual", 0, 0, 1, 8'h03, 0, 1, 2'd1);
        step("t5.none", 0, 0, 1, 8'h03, 0, 1, 2'd1);

        // 5b: climb to lvl 3, then a delayed stage fires at the top level
        setup(2'd0, 8'h00, 8'h00, cfgw(16'd0, 2'd0, 1'b0, 1'b0));
        setup(2'd1, 8'h00, 8'h00, cfgw(16'd0, 2'd1, 1'b0, 1'b0));
        setup(2'd2, 8'h00, 8'h00, cfgw(16'd0, 2'd2, 1'b0, 1'b0));
        setup(2'd3, 8'hFF, 8'h55, cfgw(16'd4, 2'd0, 1'b0, 1'b0));
        step("t5.arm2", 0, 1, 0, 8'h00, 0, 1, 2'd0);
        step("t5.l1",   0, 0, 1, 8'h55, 0, 1, 2'd1);
        step("t5.l2",   0, 0, 1, 8'h00, 0, 1, 2'd2);
        step("t5.l3",   0, 0, 1, 8'h00, 0, 1, 2'd3);
        step("t5.cnt",  0, 0, 1, 8'h00, 0, 1, 2'd3);
        step("t5.sat",  0, 0, 1, 8'h00, 0, 1, 2'd3);

        // 6: arm beats a coincident strobe; reset during a pending delay
        setup(2'd0, 8'hFF, 8'h11, cfgw(16'd0, 2'd0, 1'b0, 1'b1));
        setup(2'd1, 8'hFF, 8'h22, cfgw(16'd5, 2'd0, 1'b0, 1'b1));
        park(2'd2); park(2'd3);
        step("t6.armstb", 0, 1, 1, 8'h11, 0, 1, 2'd0);
        step("t6.dly",    0, 0, 1, 8'h22, 0, 1, 2'd0);
        step("t6.dly2",   0, 0, 1, 8'h00, 0, 1, 2'd0);
        step("t6.rst",    1, 0, 0, 8'h00, 0, 0, 2'd0);
        step("t6.p11",    0, 0, 1, 8'h11, 0, 0, 2'd0);
        step("t6.p22",    0, 0, 1, 8'h22, 0, 0, 2'd0);
        for (int i = 0; i < 5; i++) begin
            step($sformatf("t6.post%0d", i), 0, 0, 1, 8'h00, 0, 0, 2'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
